alu_stage: RTL

Execute/writeback stage placed directly downstream of the register file's read ports and upstream of its write port. It accepts one instruction per handshake, drives the two read addresses, and captures operands after the register file's one-cycle registered read. It then computes a single-cycle ALU result, or an iterative multiply result, and writes it back through the register file's write port. It is the first sequential consumer of `reg_file` and closes the read-execute-write loop.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/shift_add_mul.sv | 72 +++++++
 rtl/alu_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute/writeback stage: opcode width, opcode
// encodings and the stage FSM state type.
// Ports: none (package).
// Optional feature macro used by importers: ALU_STAGE_MUL_EN.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int OP_WIDTH = 4;

  // Encodings 10..15 are undefined and raise op_err in the stage.
  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SLTU = 4'd7,
    OP_MUL  = 4'd8,
    OP_MOV  = 4'd9
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_MUL  = 3'd3,
    ST_WB   = 3'd4
  } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// -----------------------------------------------------------------------------
// shift_add_mul
// Iterative shift-add multiplier returning the low DATA_WIDTH bits of a*b.
// One bit of b is consumed per cycle; a start pulse loads the operands and
// done_o is asserted during the DATA_WIDTH-th step, with product_o carrying
// the finished product in that same cycle (it is the accumulator's next value).
// Only instantiated by alu_stage when ALU_STAGE_MUL_EN is defined.
// Ports:
//   clock      in   clock, all state on posedge
//   reset_n    in   asynchronous active-low reset
//   start_i    in   load operands and begin a multiply
//   a_i, b_i   in   operands (DATA_WIDTH)
//   done_o     out  final step in progress; product_o is valid
//   product_o  out  low DATA_WIDTH bits of the product
// -----------------------------------------------------------------------------
module shift_add_mul #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] product_o
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] addend_q;  // a, shifted left once per step
  logic [DATA_WIDTH-1:0] scan_q;    // b, shifted right once per step
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] acc_d;
  logic [CW-1:0]         count_q;
  logic                  active_q;

  always_comb begin
    acc_d = acc_q;
    if (scan_q[0]) begin
      acc_d = acc_q + addend_q;
    end
  end

  assign done_o    = active_q && (count_q == LAST_STEP);
  assign product_o = acc_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addend_q <= '0;
      scan_q   <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      addend_q <= a_i;
      scan_q   <= b_i;
      acc_q    <= '0;
      count_q  <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      acc_q    <= acc_d;
      addend_q <= addend_q << 1;
      scan_q   <= scan_q >> 1;
      count_q  <= count_q + 1'b1;
      if (count_q == LAST_STEP) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_stage.sv
// -----------------------------------------------------------------------------
// alu_stage
// Execute/writeback stage between the register file read ports and its write
// port. Accepts one instruction per handshake in IDLE, drives registered read
// addresses, waits one cycle for the register file's registered read, then
// computes the result (single cycle, or iterative multiply) and issues a
// one-cycle write.
// Optional feature: define ALU_STAGE_MUL_EN to enable opcode 8 (MUL) through
// the shift_add_mul sub-module. Without it opcode 8 is undefined.
// Ports:
//   clock, reset_n                    clock / asynchronous active-low reset
//   in_valid, in_ready                instruction handshake (ready = IDLE)
//   in_op, in_src1, in_src2, in_dst   instruction fields
//   r1_addr, r2_addr                  registered register-file read addresses
//   r1_data, r2_data                  register-file read data
//   write_addr, write_data, write_ctrl registered register-file write port
//   busy                              high in every state except IDLE
//   op_err                            one-cycle pulse on an undefined opcode
// -----------------------------------------------------------------------------
module alu_stage
  import alu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   in_op,
  input  logic [ADDR_WIDTH-1:0] in_src1,
  input  logic [ADDR_WIDTH-1:0] in_src2,
  input  logic [ADDR_WIDTH-1:0] in_dst,
  output logic [ADDR_WIDTH-1:0] r1_addr,
  output logic [ADDR_WIDTH-1:0] r2_addr,
  input  logic [DATA_WIDTH-1:0] r1_data,
  input  logic [DATA_WIDTH-1:0] r2_data,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_ctrl,
  output logic                  busy,
  output logic                  op_err
);

  localparam logic [DATA_WIDTH-1:0] DW_CONST = DATA_WIDTH'(DATA_WIDTH);

  state_e                state_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [ADDR_WIDTH-1:0] r1_addr_q;
  logic [ADDR_WIDTH-1:0] r2_addr_q;
  logic [ADDR_WIDTH-1:0] write_addr_q;
  logic [DATA_WIDTH-1:0] write_data_q;
  logic                  write_ctrl_q;
  logic                  op_err_q;

  logic [DATA_WIDTH-1:0] alu_res_d;
  logic                  alu_def_d;
  logic [DATA_WIDTH-1:0] shamt;

  // Handshake and status are pure state decodes: no path from in_valid.
  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign r1_addr    = r1_addr_q;
  assign r2_addr    = r2_addr_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign write_ctrl = write_ctrl_q;
  assign op_err     = op_err_q;

  assign shamt = r2_data % DW_CONST;

  // Single-cycle datapath, evaluated while in EXEC. MUL is not handled here,
  // so it decodes as undefined unless the multiplier path intercepts it.
  always_comb begin
    alu_res_d = '0;
    alu_def_d = 1'b1;
    case (op_q)
      OP_ADD:  alu_res_d = r1_data + r2_data;
      OP_SUB:  alu_res_d = r1_data - r2_data;
      OP_AND:  alu_res_d = r1_data & r2_data;
      OP_OR:   alu_res_d = r1_data | r2_data;
      OP_XOR:  alu_res_d = r1_data ^ r2_data;
      OP_SHL:  alu_res_d = r1_data << shamt;
      OP_SHR:  alu_res_d = r1_data >> shamt;
      OP_SLTU: alu_res_d = {{(DATA_WIDTH-1){1'b0}}, (r1_data < r2_data)};
      OP_MOV:  alu_res_d = r1_data;
      default: alu_def_d = 1'b0;
    endcase
  end

`ifdef ALU_STAGE_MUL_EN
  logic                  mul_start;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;

  // Operands are captured by the multiplier on the EXEC edge.
  assign mul_start = (state_q == ST_EXEC) && (op_q == OP_MUL);

  shift_add_mul #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mul (
    .clock     (clock),
    .reset_n   (reset_n),
    .start_i   (mul_start),
    .a_i       (r1_data),
    .b_i       (r2_data),
    .done_o    (mul_done),
    .product_o (mul_product)
  );
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      dst_q        <= '0;
      r1_addr_q    <= '0;
      r2_addr_q    <= '0;
      write_addr_q <= '0;
      write_data_q <= '0;
      write_ctrl_q <= 1'b0;
      op_err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q      <= in_op;
            dst_q     <= in_dst;
            r1_addr_q <= in_src1;
            r2_addr_q <= in_src2;
            state_q   <= ST_READ;
          end
        end
        ST_READ: begin
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          state_q <= ST_WB;
`ifdef ALU_STAGE_MUL_EN
          if (op_q == OP_MUL) begin
            state_q <= ST_MUL;
          end else
`endif
          if (alu_def_d) begin
            write_data_q <= alu_res_d;
            write_addr_q <= dst_q;
            write_ctrl_q <= 1'b1;
          end else begin
            op_err_q <= 1'b1;
          end
        end
`ifdef ALU_STAGE_MUL_EN
        ST_MUL: begin
          if (mul_done) begin
            write_data_q <= mul_product;
            write_addr_q <= dst_q;
            write_ctrl_q <= 1'b1;
            state_q      <= ST_WB;
          end
        end
`endif
        ST_WB: begin
          write_ctrl_q <= 1'b0;
          op_err_q     <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
